// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for monitoring a SoC tx pin: synchronizer, bit-timing FSM,
// and a small byte FIFO with one-cycle frame-error and overflow pulses.
module uart_rx_monitor #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          push_req;
  logic          frame_err_set;
  logic          rx_meta, rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, do_push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  // Every phase counts down to zero and acts on the sample taken at expiry.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    push_req      = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = HALF_RELOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
            cnt_next     = FULL_RELOAD;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_next[bit_idx] = rx_s;
          cnt_next            = FULL_RELOAD;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push_req   = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o  = (state != IDLE);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid_o = !empty;
  assign data_o  = mem[rd_ptr[AW-1:0]];
  assign pop     = valid_o && ready_i;
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      frame_err_o <= frame_err_set;
      overflow_o  <= push_req && full && !pop;
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed plus randomized bench for uart_rx_monitor: a byte-level model
// predicts deliveries, frame errors and overflows from the frames sent.
module tb_uart_rx_monitor;

  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overflow_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
  int hold_err = 0, stab_err = 0;
  logic prev_fe = 1'b0, prev_ov = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = '0;
  logic busy_mid;

  uart_rx_monitor #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .frame_err_o(frame_err_o),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Observe on the falling edge, between the rising edges where state moves.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_fe = 1'b0; prev_ov = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    end else begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o) fe_cnt++;
      if (overflow_o) ov_cnt++;
      if ((frame_err_o && prev_fe) || (overflow_o && prev_ov)) hold_err++;
      if (prev_valid && !prev_ready && valid_o && data_o !== prev_data) stab_err++;
      prev_fe = frame_err_o; prev_ov = overflow_o;
      prev_valid = valid_o; prev_ready = ready_i; prev_data = data_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(CLK_DIV);
  endtask

  // One 8N1 frame; optionally pulses ready_i in the cycle the stop bit is sampled.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_val, input bit pop_at_push);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    busy_mid = busy_o;
    rx_i = stop_val;
    if (pop_at_push) begin
      tick(CLK_DIV - 2);
      ready_i = 1'b1;
      tick(1);
      ready_i = 1'b0;
      tick(1);
    end else begin
      tick(CLK_DIV);
    end
  endtask

  // Model: a good frame is delivered unless DEPTH bytes are already waiting.
  task automatic model_push(input logic [7:0] b, input bit pop_same);
    if ((exp_q.size() - got_q.size()) < FIFO_DEPTH || pop_same) exp_q.push_back(b);
    else exp_ov++;
  endtask

  task automatic compare_delivered(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    checkOutput({tag, "_frame_err"}, fe_cnt, exp_fe);
    checkOutput({tag, "_overflow"}, ov_cnt, exp_ov);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    rst_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0;
    tick(3);
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_data", data_o, 8'h00);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_flags", {frame_err_o, overflow_o}, 2'b00);
    rst_i = 1'b0;
    tick(2 * CLK_DIV);

    $display("[TB] single byte 0xA5");
    ready_i = 1'b1;
    applyStimulus(8'hA5, 1'b1, 0);
    model_push(8'hA5, 0);
    checkOutput("a5_busy_mid", busy_mid, 1'b1);
    checkOutput("a5_busy_after", busy_o, 1'b0);
    tick(CLK_DIV);
    compare_delivered("a5");

    $display("[TB] start glitch");
    rx_i = 1'b0; tick(3); rx_i = 1'b1;
    tick(2 * CLK_DIV);
    checkOutput("glitch_busy", busy_o, 1'b0);
    compare_delivered("glitch");

    $display("[TB] frame error with break");
    applyStimulus(8'h3C, 1'b0, 0);
    exp_fe++;
    tick(19 * CLK_DIV);
    checkOutput("break_busy_low_line", busy_o, 1'b1);
    rx_i = 1'b1;
    tick(CLK_DIV);
    checkOutput("break_busy_released", busy_o, 1'b0);
    compare_delivered("break");

    $display("[TB] overflow with ready low");
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) checkOutput("ovf_none_before_5", ov_cnt, 0);
      applyStimulus(8'(i), 1'b1, 0);
      model_push(8'(i), 0);
      tick(CLK_DIV);
    end
    checkOutput("ovf_pulse_on_5", ov_cnt, 1);
    ready_i = 1'b1;
    tick(2 * FIFO_DEPTH);
    checkOutput("ovf_drained", valid_o, 1'b0);
    compare_delivered("ovf");

    $display("[TB] push and pop in the same cycle while full");
    ready_i = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b, 1'b1, 0);
      model_push(b, 0);
      tick(CLK_DIV);
    end
    checkOutput("full_valid", valid_o, 1'b1);
    applyStimulus(8'h66, 1'b1, 1);
    model_push(8'h66, 1);
    tick(CLK_DIV);
    ready_i = 1'b1;
    tick(2 * FIFO_DEPTH);
    compare_delivered("full_pushpop");

    $display("[TB] reset during bit 4 of 0xFF");
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    tick(3);
    rst_i = 1'b1;
    tick(2);
    checkOutput("midrst_busy", busy_o, 1'b0);
    checkOutput("midrst_valid", valid_o, 1'b0);
    checkOutput("midrst_data", data_o, 8'h00);
    rst_i = 1'b0;
    tick(2 * CLK_DIV);
    applyStimulus(8'h12, 1'b1, 0);
    model_push(8'h12, 0);
    tick(CLK_DIV);
    compare_delivered("midrst");

    $display("[TB] random bytes");
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom_range(0, 255));
      applyStimulus(b, 1'b1, 0);
      model_push(b, 0);
      tick(CLK_DIV * $urandom_range(1, 3));
    end
    compare_delivered("random");

    checkOutput("pulse_single_cycle", hold_err, 0);
    checkOutput("data_stable_stalled", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
